// File: rtl/psg_pkg.sv
// Shared types and byte encoding for the SN76489 write sequencer.
// The latch byte carries channel/kind/low nibble; a tone period also needs a data byte.
package psg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    WAIT_RDY,
    HOLD
  } psg_state_e;

  localparam int         LATCH_BIT  = 7;
  localparam logic [1:0] CHAN_NOISE = 2'd3;
  localparam logic       KIND_ATTN  = 1'b1;

  function automatic logic [7:0] psg_latch_byte(input logic [1:0] chan,
                                                input logic       kind,
                                                input logic [3:0] val);
    logic [7:0] b;
    b            = '0;
    b[LATCH_BIT] = 1'b1;
    b[6:5]       = chan;
    b[4]         = kind;
    // Noise control only has three meaningful bits; bit 3 is forced low.
    if (chan == CHAN_NOISE && kind != KIND_ATTN) b[3:0] = {1'b0, val[2:0]};
    else                                         b[3:0] = val;
    return b;
  endfunction

  function automatic logic psg_needs_data(input logic [1:0] chan, input logic kind);
    return (chan != CHAN_NOISE) && (kind != KIND_ATTN);
  endfunction

endpackage

// File: rtl/psg_sync2.sv
// Two-flop synchroniser for the PSG READY pin; resets to "ready" so a write
// issued straight after reset is not held off by an unknown pin history.
module psg_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], async_i};
  end

  assign sync_o = sync_q[1];

endmodule

// File: rtl/psg_write_sequencer.sv
// Turns (channel, kind, value) commands into timed SN76489 bus writes with an
// active-low strobe that is stretched until READY, bounded by a timeout.
module psg_write_sequencer
  import psg_pkg::*;
#(
  parameter int SETUP_CYCLES   = 1,
  parameter int STROBE_CYCLES  = 32,
  parameter int HOLD_CYCLES    = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_chan,
  input  logic       cmd_kind,
  input  logic [9:0] cmd_value,
  output logic [7:0] psg_data,
  output logic       psg_we_n,
  input  logic       psg_ready,
  output logic       busy,
  output logic       err_timeout
);

  localparam int MAX_A = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_B = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] SETUP_LD   = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LD  = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LD = CW'(TIMEOUT_CYCLES - 1);

  psg_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic [5:0]    hi_q, hi_d;
  logic          pend_q, pend_d;
  logic          we_n_q, we_n_d;
  logic          err_q, err_d;
  logic          ready_s;

  psg_sync2 u_sync (
    .clk    (clk),
    .reset  (reset),
    .async_i(psg_ready),
    .sync_o (ready_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    hi_d    = hi_q;
    pend_d  = pend_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = SETUP;
          cnt_d   = SETUP_LD;
          data_d  = psg_latch_byte(cmd_chan, cmd_kind, cmd_value[3:0]);
          hi_d    = cmd_value[9:4];
          pend_d  = psg_needs_data(cmd_chan, cmd_kind);
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = WAIT_RDY;
          cnt_d   = TIMEOUT_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WAIT_RDY: begin
        // A timed-out write still completes normally; only the error pulse differs.
        if (ready_s || cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
          err_d   = !ready_s;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (pend_q) begin
          state_d = SETUP;
          cnt_d   = SETUP_LD;
          data_d  = {2'b00, hi_q};
          pend_d  = 1'b0;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Strobe is registered from the next state so the pin cannot glitch.
    we_n_d = !((state_d == STROBE) || (state_d == WAIT_RDY));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      hi_q    <= '0;
      pend_q  <= 1'b0;
      we_n_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      hi_q    <= hi_d;
      pend_q  <= pend_d;
      we_n_q  <= we_n_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign psg_data    = data_q;
  assign psg_we_n    = we_n_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_psg_write_sequencer.sv
// Bench for psg_write_sequencer: instance A uses default timing, instance B a
// short READY timeout. Bus writes are captured by monitors and scored against a model.
module tb_psg_write_sequencer;

  typedef struct {
    logic [7:0] b;
    int         low;
    bit         stable;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid_a, cmd_valid_b;
  logic [1:0] cmd_chan;
  logic       cmd_kind;
  logic [9:0] cmd_value;
  logic       psg_ready_a, psg_ready_b;
  logic       cmd_ready_a, cmd_ready_b;
  logic [7:0] psg_data_a, psg_data_b;
  logic       psg_we_n_a, psg_we_n_b;
  logic       busy_a, busy_b;
  logic       err_timeout_a, err_timeout_b;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] exp_a[$], exp_b[$];
  wr_t        obs_a[$], obs_b[$];
  int         err_a = 0, err_b = 0;

  always #5 clk = ~clk;

  psg_write_sequencer dut_a (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_chan(cmd_chan), .cmd_kind(cmd_kind), .cmd_value(cmd_value),
    .psg_data(psg_data_a), .psg_we_n(psg_we_n_a), .psg_ready(psg_ready_a),
    .busy(busy_a), .err_timeout(err_timeout_a)
  );

  psg_write_sequencer #(.TIMEOUT_CYCLES(8)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_chan(cmd_chan), .cmd_kind(cmd_kind), .cmd_value(cmd_value),
    .psg_data(psg_data_b), .psg_we_n(psg_we_n_b), .psg_ready(psg_ready_b),
    .busy(busy_b), .err_timeout(err_timeout_b)
  );

  // Write capture: one record per strobe, with its low length and whether the
  // byte was already on the bus a cycle before the fall and still there after the rise.
  logic       pw_a = 1'b1, pw_b = 1'b1;
  logic [7:0] pd_a, pd_b, cb_a, cb_b;
  int         lc_a, lc_b;
  bit         st_a, st_b;

  always @(negedge clk) begin
    if (err_timeout_a === 1'b1) err_a++;
    if (psg_we_n_a === 1'b0) begin
      if (pw_a) begin cb_a = psg_data_a; lc_a = 1; st_a = (pd_a === psg_data_a); end
      else begin lc_a++; if (psg_data_a !== cb_a) st_a = 0; end
    end else if (!pw_a) begin
      obs_a.push_back('{cb_a, lc_a, st_a && (psg_data_a === cb_a)});
    end
    pw_a = (psg_we_n_a !== 1'b0);
    pd_a = psg_data_a;
  end

  always @(negedge clk) begin
    if (err_timeout_b === 1'b1) err_b++;
    if (psg_we_n_b === 1'b0) begin
      if (pw_b) begin cb_b = psg_data_b; lc_b = 1; st_b = (pd_b === psg_data_b); end
      else begin lc_b++; if (psg_data_b !== cb_b) st_b = 0; end
    end else if (!pw_b) begin
      obs_b.push_back('{cb_b, lc_b, st_b && (psg_data_b === cb_b)});
    end
    pw_b = (psg_we_n_b !== 1'b0);
    pd_b = psg_data_b;
  end

  task automatic push_exp(input bit which, input logic [1:0] ch, input logic k,
                          input logic [9:0] v);
    logic [7:0] lb;
    logic [7:0] db;
    bit         two;
    two = 0;
    if (k)             lb = {1'b1, ch, 1'b1, v[3:0]};
    else if (ch == 2'd3) lb = {5'b11100, v[2:0]};
    else begin
      lb  = {1'b1, ch, 1'b0, v[3:0]};
      db  = {2'b00, v[9:4]};
      two = 1;
    end
    if (which) begin exp_b.push_back(lb); if (two) exp_b.push_back(db); end
    else begin exp_a.push_back(lb); if (two) exp_a.push_back(db); end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input bit which, input logic [1:0] ch, input logic k,
                      input logic [9:0] v);
    push_exp(which, ch, k, v);
    cmd_chan  = ch;
    cmd_kind  = k;
    cmd_value = v;
    if (which) cmd_valid_b = 1'b1; else cmd_valid_a = 1'b1;
    @(negedge clk);
    cmd_valid_a = 1'b0;
    cmd_valid_b = 1'b0;
  endtask

  task automatic wait_idle(input bit which, input int budget, output int cyc);
    cyc = 0;
    while (((which ? busy_b : busy_a) !== 1'b0) && cyc < budget) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic take(input bit which, output logic [7:0] want, output wr_t got,
                      output bit have);
    want = which ? exp_b.pop_front() : exp_a.pop_front();
    have = which ? (obs_b.size() > 0) : (obs_a.size() > 0);
    got  = '{8'h00, -1, 1'b0};
    if (have) got = which ? obs_b.pop_front() : obs_a.pop_front();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_total++; if (cmd_ready_a !== 1'b1) $display("FAIL rst_cmd_ready got %b want 1", cmd_ready_a); else n_pass++;
    n_total++; if (psg_data_a !== 8'h00) $display("FAIL rst_data got %h want 00", psg_data_a); else n_pass++;
    n_total++; if (psg_we_n_a !== 1'b1) $display("FAIL rst_we_n got %b want 1", psg_we_n_a); else n_pass++;
    n_total++; if (busy_a !== 1'b0) $display("FAIL rst_busy got %b want 0", busy_a); else n_pass++;
    n_total++; if (err_timeout_a !== 1'b0) $display("FAIL rst_err got %b want 0", err_timeout_a); else n_pass++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tone;
    int cyc; logic [7:0] want; wr_t got; bit have;
    send(0, 2'd1, 1'b0, 10'h2A5);
    n_total++; if (busy_a !== 1'b1) $display("FAIL tone_busy got %b want 1", busy_a); else n_pass++;
    n_total++; if (cmd_ready_a !== 1'b0) $display("FAIL tone_cmd_ready got %b want 0", cmd_ready_a); else n_pass++;
    wait_idle(0, 500, cyc);
    n_total++; if (cyc !== 70) $display("FAIL tone_busy_cycles got %0d want 70", cyc); else n_pass++;
    n_total++; if (cmd_ready_a !== 1'b1) $display("FAIL tone_ready_end got %b want 1", cmd_ready_a); else n_pass++;
    while (exp_a.size() > 0) begin
      take(0, want, got, have);
      n_total++; if (!have || got.b !== want) $display("FAIL tone_byte got %h want %h", got.b, want); else n_pass++;
      n_total++; if (got.low !== 33 || !got.stable) $display("FAIL tone_timing low %0d stable %0d want 33 1", got.low, got.stable); else n_pass++;
    end
    n_total++; if (obs_a.size() !== 0) $display("FAIL tone_extra got %0d writes want 0", obs_a.size()); else n_pass++;
  endtask

  task automatic test_attn;
    int cyc; logic [7:0] want; wr_t got; bit have;
    send(0, 2'd2, 1'b1, 10'h00F);
    wait_idle(0, 500, cyc);
    n_total++; if (cyc !== 35) $display("FAIL attn_busy_cycles got %0d want 35", cyc); else n_pass++;
    n_total++; if (cmd_ready_a !== 1'b1) $display("FAIL attn_ready_end got %b want 1", cmd_ready_a); else n_pass++;
    take(0, want, got, have);
    n_total++; if (!have || got.b !== want) $display("FAIL attn_byte got %h want %h", got.b, want); else n_pass++;
    n_total++; if (got.low !== 33 || !got.stable) $display("FAIL attn_timing low %0d stable %0d want 33 1", got.low, got.stable); else n_pass++;
    n_total++; if (obs_a.size() !== 0) $display("FAIL attn_extra got %0d writes want 0", obs_a.size()); else n_pass++;
  endtask

  task automatic test_noise_busy_ignore;
    int cyc; logic [7:0] want; wr_t got; bit have;
    send(0, 2'd3, 1'b0, 10'h3FD);
    // A command offered while busy must not be taken.
    cmd_chan = 2'd0; cmd_kind = 1'b0; cmd_value = 10'h3FF; cmd_valid_a = 1'b1;
    repeat (10) @(negedge clk);
    cmd_valid_a = 1'b0;
    wait_idle(0, 500, cyc);
    n_total++; if (cyc !== 25) $display("FAIL noise_busy_cycles got %0d want 25", cyc); else n_pass++;
    take(0, want, got, have);
    n_total++; if (!have || got.b !== want) $display("FAIL noise_byte got %h want %h", got.b, want); else n_pass++;
    n_total++; if (obs_a.size() !== 0) $display("FAIL noise_extra got %0d writes want 0", obs_a.size()); else n_pass++;
  endtask

  task automatic test_ready_wait;
    int cyc; int n; logic [7:0] want; wr_t got; bit have;
    psg_ready_a = 1'b0;
    repeat (3) @(negedge clk);
    err_a = 0;
    send(0, 2'd0, 1'b1, 10'h005);
    n = 0;
    while (psg_we_n_a !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    repeat (49) @(negedge clk);
    n_total++; if (psg_we_n_a !== 1'b0) $display("FAIL rdy_we_low got %b want 0", psg_we_n_a); else n_pass++;
    psg_ready_a = 1'b1;
    wait_idle(0, 500, cyc);
    take(0, want, got, have);
    n_total++; if (!have || got.b !== want) $display("FAIL rdy_byte got %h want %h", got.b, want); else n_pass++;
    n_total++; if (got.low !== 52) $display("FAIL rdy_low_cycles got %0d want 52", got.low); else n_pass++;
    n_total++; if (err_a !== 0) $display("FAIL rdy_err_pulses got %0d want 0", err_a); else n_pass++;
  endtask

  task automatic test_timeout;
    int cyc; logic [7:0] want; wr_t got; bit have;
    psg_ready_b = 1'b0;
    repeat (3) @(negedge clk);
    err_b = 0;
    send(1, 2'd2, 1'b0, 10'h13C);
    wait_idle(1, 500, cyc);
    n_total++; if (cyc !== 84) $display("FAIL to_busy_cycles got %0d want 84", cyc); else n_pass++;
    n_total++; if (err_b !== 2) $display("FAIL to_err_pulses got %0d want 2", err_b); else n_pass++;
    n_total++; if (cmd_ready_b !== 1'b1) $display("FAIL to_ready_end got %b want 1", cmd_ready_b); else n_pass++;
    while (exp_b.size() > 0) begin
      take(1, want, got, have);
      n_total++; if (!have || got.b !== want) $display("FAIL to_byte got %h want %h", got.b, want); else n_pass++;
      n_total++; if (got.low !== 40) $display("FAIL to_low_cycles got %0d want 40", got.low); else n_pass++;
    end
    psg_ready_b = 1'b1;
  endtask

  task automatic test_reset_mid;
    int n;
    send(0, 2'd1, 1'b0, 10'h3C7);
    n = 0;
    while (psg_we_n_a !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_total++; if (psg_we_n_a !== 1'b1) $display("FAIL mid_we_n got %b want 1", psg_we_n_a); else n_pass++;
    n_total++; if (cmd_ready_a !== 1'b1) $display("FAIL mid_cmd_ready got %b want 1", cmd_ready_a); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    exp_a.delete();
    obs_a.delete();
    repeat (80) @(negedge clk);
    n_total++; if (obs_a.size() !== 0) $display("FAIL mid_no_second got %0d writes want 0", obs_a.size()); else n_pass++;
    n_total++; if (busy_a !== 1'b0) $display("FAIL mid_busy got %b want 0", busy_a); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int cyc; int n; logic [7:0] want; wr_t got; bit have;
    send(0, 2'd0, 1'b0, 10'h1E3);
    push_exp(0, 2'd1, 1'b1, 10'h007);
    cmd_chan = 2'd1; cmd_kind = 1'b1; cmd_value = 10'h007; cmd_valid_a = 1'b1;
    n = 0;
    while (cmd_ready_a !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid_a = 1'b0;
    n_total++; if (n !== 70) $display("FAIL b2b_first_cycles got %0d want 70", n); else n_pass++;
    n_total++; if (busy_a !== 1'b1) $display("FAIL b2b_second_busy got %b want 1", busy_a); else n_pass++;
    wait_idle(0, 500, cyc);
    n_total++; if (cyc !== 35) $display("FAIL b2b_second_cycles got %0d want 35", cyc); else n_pass++;
    while (exp_a.size() > 0) begin
      take(0, want, got, have);
      n_total++; if (!have || got.b !== want) $display("FAIL b2b_byte got %h want %h", got.b, want); else n_pass++;
    end
    n_total++; if (obs_a.size() !== 0) $display("FAIL b2b_extra got %0d writes want 0", obs_a.size()); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    cmd_valid_a = 1'b0;
    cmd_valid_b = 1'b0;
    cmd_chan    = 2'd0;
    cmd_kind    = 1'b0;
    cmd_value   = 10'h000;
    psg_ready_a = 1'b1;
    psg_ready_b = 1'b1;
    @(negedge clk);
    test_reset();
    test_tone();
    test_attn();
    test_noise_busy_ignore();
    test_ready_wait();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
